// File: rtl/unidad_de_control_multiciclo_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// RV32I opcodes, ALU operation codes and datapath mux select codes.
package pkg_control;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      EXECI,
      ALUWB,
      BEQ,
      LUI,
      ILLEGAL
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_U = 2'b10;
   localparam logic [1:0] IMM_B = 2'b11;

   // Instruction-field format presented to the sign extender for a given opcode.
   function automatic logic [1:0] imm_fmt_of(input logic [6:0] op);
      logic [1:0] fmt;
      case (op)
         OP_STORE: fmt = IMM_S;
         OP_LUI:   fmt = IMM_U;
         OP_BEQ:   fmt = IMM_B;
         default:  fmt = IMM_I;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/unidad_de_control_multiciclo_if.sv
// Memory handshake between the control unit (master) and the memory system (slave).
interface unidad_de_control_multiciclo_if;
   logic mem_req;
   logic mem_write;
   logic adr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
   modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/unidad_de_control_multiciclo_decodificador_alu.sv
// ALU operation decoder for register and immediate arithmetic instructions.
module decodificador_alu
   import pkg_control::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [2:0] alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         // funct7b5 only selects subtraction for R-type; addi ignores it.
         3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_op = ALU_AND;
         3'b110:  alu_op = ALU_OR;
         3'b010:  alu_op = ALU_SLT;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// aborts memory accesses that wait longer than WAIT_MAX cycles.
module unidad_de_control_multiciclo
   import pkg_control::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [6:0]                      opcode,
   input  logic [2:0]                      funct3,
   input  logic                            funct7b5,
   input  logic                            zero,
   unidad_de_control_multiciclo_if.master  mem_bus,
   output logic                            ir_write,
   output logic                            pc_write,
   output logic                            reg_write,
   output logic [1:0]                      alu_src_a,
   output logic [1:0]                      alu_src_b,
   output logic [2:0]                      alu_op,
   output logic [1:0]                      result_src,
   output logic [1:0]                      imm_fmt,
   output logic                            imn_src,
   output logic                            illegal_instr,
   output logic                            bus_error
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             is_wait;
   logic             timeout;
   logic [2:0]       exec_op;
   logic             mem_req_c, mem_write_c, adr_src_c;

   assign is_wait = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
   // A ready on the final allowed cycle wins over the timeout.
   assign timeout = is_wait && !mem_bus.mem_ready && (wait_cnt_q == CNT_W'(WAIT_MAX));

   decodificador_alu u_decodificador_alu (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_rtype (state_q == EXECR),
      .alu_op   (exec_op)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      case (state_q)
         FETCH: begin
            if (mem_bus.mem_ready)  state_d = DECODE;
            else if (timeout)       state_d = FETCH;
            else                    wait_cnt_d = wait_cnt_q + 1'b1;
         end
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BEQ:            state_d = BEQ;
               OP_LUI:            state_d = LUI;
               default:           state_d = ILLEGAL;
            endcase
         end
         MEMADR:  state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
         MEMREAD: begin
            if (mem_bus.mem_ready)  state_d = MEMWB;
            else if (timeout)       state_d = FETCH;
            else                    wait_cnt_d = wait_cnt_q + 1'b1;
         end
         MEMWRITE: begin
            if (mem_bus.mem_ready || timeout) state_d = FETCH;
            else                              wait_cnt_d = wait_cnt_q + 1'b1;
         end
         EXECR, EXECI: state_d = ALUWB;
         default:      state_d = FETCH;
      endcase
   end

   always_comb begin
      mem_req_c     = 1'b0;
      mem_write_c   = 1'b0;
      adr_src_c     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALU_ADD;
      result_src    = RES_ALUOUT;
      imm_fmt       = IMM_I;
      imn_src       = 1'b0;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;
      if (!reset) begin
         imm_fmt = imm_fmt_of(opcode);
         imn_src = (imm_fmt_of(opcode) == IMM_U);
         case (state_q)
            FETCH: begin
               mem_req_c  = !timeout;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
               ir_write   = mem_bus.mem_ready;
               pc_write   = mem_bus.mem_ready;
               bus_error  = timeout;
            end
            DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
               mem_req_c = !timeout;
               adr_src_c = 1'b1;
               bus_error = timeout;
            end
            MEMWB: begin
               result_src = RES_DATA;
               reg_write  = 1'b1;
            end
            MEMWRITE: begin
               mem_req_c   = !timeout;
               mem_write_c = !timeout;
               adr_src_c   = 1'b1;
               bus_error   = timeout;
            end
            EXECR, EXECI: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = (state_q == EXECI) ? SRCB_IMM : SRCB_RS2;
               alu_op    = exec_op;
            end
            ALUWB: begin
               result_src = RES_ALUOUT;
               reg_write  = 1'b1;
            end
            BEQ: begin
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_RS2;
               alu_op     = ALU_SUB;
               result_src = RES_ALUOUT;
               pc_write   = zero;
            end
            LUI: begin
               result_src = RES_IMM;
               reg_write  = 1'b1;
            end
            ILLEGAL: illegal_instr = 1'b1;
            default: ;
         endcase
      end
   end

   assign mem_bus.mem_req   = mem_req_c;
   assign mem_bus.mem_write = mem_write_c;
   assign mem_bus.adr_src   = adr_src_c;

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Randomized scoreboard bench: per-cycle expected control words come from a
// phase-sequence model of each instruction and are checked by a separate monitor.
module tb_unidad_de_control_multiciclo;

   localparam int WAIT_MAX = 15;

   typedef enum int {
      P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
      P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_LUI, P_ILLEGAL
   } ph_e;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] a;
      logic [1:0] b;
      logic [2:0] op;
      logic [1:0] rs;
      logic [1:0] fmt;
      logic       imn;
      logic       ill;
      logic       berr;
   } out_t;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       ir_write, pc_write, reg_write, imn_src, illegal_instr, bus_error;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_fmt;
   logic [2:0] alu_op;

   unidad_de_control_multiciclo_if mem_bus ();

   unidad_de_control_multiciclo #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .zero          (zero),
      .mem_bus       (mem_bus),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .result_src    (result_src),
      .imm_fmt       (imm_fmt),
      .imn_src       (imn_src),
      .illegal_instr (illegal_instr),
      .bus_error     (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   out_t  q_exp[$];
   string q_tag[$];
   int    total = 0;
   int    bad   = 0;
   int    n_instr = 0;
   logic [6:0] cur_opc;
   logic [2:0] cur_f3;
   logic       cur_f7;
   logic       cur_z;

   out_t  got;
   out_t  mon_exp;
   string mon_tag;

   assign got = {mem_bus.mem_req, mem_bus.mem_write, mem_bus.adr_src, ir_write, pc_write,
                 reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_fmt, imn_src,
                 illegal_instr, bus_error};

   // Expected ALU operation for arithmetic instructions, straight from the funct3 table.
   function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic want_sub);
      if (f3 == 3'd0) return want_sub ? 3'd1 : 3'd0;
      if (f3 == 3'd7) return 3'd2;
      if (f3 == 3'd6) return 3'd3;
      if (f3 == 3'd2) return 3'd5;
      return 3'd0;
   endfunction

   function automatic out_t model(input ph_e ph, input logic [6:0] opc, input logic [2:0] f3,
                                  input logic f7, input logic z, input logic rdy, input logic tmo);
      out_t o;
      o = '0;
      if (ph == P_RST) return o;
      o.fmt = (opc == 7'h23) ? 2'd1 : (opc == 7'h37) ? 2'd2 : (opc == 7'h63) ? 2'd3 : 2'd0;
      o.imn = (opc == 7'h37);
      case (ph)
         P_FETCH:    begin o.mem_req = !tmo; o.ir_write = rdy; o.pc_write = rdy;
                           o.b = 2'd2; o.rs = 2'd2; o.berr = tmo; end
         P_DECODE:   begin o.a = 2'd1; o.b = 2'd1; end
         P_MEMADR:   begin o.a = 2'd2; o.b = 2'd1; end
         P_MEMREAD:  begin o.mem_req = !tmo; o.adr_src = 1'b1; o.berr = tmo; end
         P_MEMWB:    begin o.rs = 2'd1; o.reg_write = 1'b1; end
         P_MEMWRITE: begin o.mem_req = !tmo; o.mem_write = !tmo; o.adr_src = 1'b1; o.berr = tmo; end
         P_EXECR:    begin o.a = 2'd2; o.b = 2'd0; o.op = alu_ref(f3, f7); end
         P_EXECI:    begin o.a = 2'd2; o.b = 2'd1; o.op = alu_ref(f3, 1'b0); end
         P_ALUWB:    o.reg_write = 1'b1;
         P_BEQ:      begin o.a = 2'd2; o.b = 2'd0; o.op = 3'd1; o.pc_write = z; end
         P_LUI:      begin o.rs = 2'd3; o.reg_write = 1'b1; end
         P_ILLEGAL:  o.ill = 1'b1;
         default:    ;
      endcase
      return o;
   endfunction

   task automatic step(input ph_e ph, input logic rdy, input logic rst, input logic tmo, input string tag);
      @(posedge clk);
      #2;
      reset             = rst;
      mem_bus.mem_ready = rdy;
      opcode            = cur_opc;
      funct3            = cur_f3;
      funct7b5          = cur_f7;
      zero              = cur_z;
      q_exp.push_back(model(ph, cur_opc, cur_f3, cur_f7, cur_z, rdy, tmo));
      q_tag.push_back($sformatf("i%0d/%s", n_instr, tag));
   endtask

   // lat = wait cycles before ready; above WAIT_MAX means ready never comes.
   task automatic mem_wait(input ph_e ph, input int lat, input int rst_at, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= WAIT_MAX; i++) begin
         if (i == rst_at) begin
            step(P_RST, 1'b0, 1'b1, 1'b0, "reset");
            return;
         end
         if (i == lat) begin
            step(ph, 1'b1, 1'b0, 1'b0, "ready");
            ok = 1'b1;
            return;
         end
         if (i == WAIT_MAX) begin
            step(ph, 1'b0, 1'b0, 1'b1, "timeout");
            return;
         end
         step(ph, 1'b0, 1'b0, 1'b0, "wait");
      end
   endtask

   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic z, input int lf, input int lm, input int rst_at);
      bit ok;
      n_instr++;
      cur_opc = opc; cur_f3 = f3; cur_f7 = f7; cur_z = z;
      $display("instr %0d opcode=%02h funct3=%0d f7b5=%0d zero=%0d fetch_lat=%0d mem_lat=%0d",
               n_instr, opc, f3, f7, z, lf, lm);
      mem_wait(P_FETCH, lf, -1, ok);
      if (!ok) return;
      step(P_DECODE, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "decode");
      case (opc)
         7'h03: begin
            step(P_MEMADR, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "memadr");
            mem_wait(P_MEMREAD, lm, rst_at, ok);
            if (ok) step(P_MEMWB, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "memwb");
         end
         7'h23: begin
            step(P_MEMADR, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "memadr");
            mem_wait(P_MEMWRITE, lm, -1, ok);
         end
         7'h33: begin
            step(P_EXECR, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "execr");
            step(P_ALUWB, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "aluwb");
         end
         7'h13: begin
            step(P_EXECI, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "execi");
            step(P_ALUWB, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "aluwb");
         end
         7'h63: step(P_BEQ, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "beq");
         7'h37: step(P_LUI, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "lui");
         default: step(P_ILLEGAL, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "illegal");
      endcase
   endtask

   function automatic int rand_lat();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 12) return r % 3;
      if (r < 16) return int'($urandom_range(3, 14));
      if (r < 18) return WAIT_MAX;
      return int'($urandom_range(WAIT_MAX + 1, WAIT_MAX + 5));
   endfunction

   function automatic logic [6:0] rand_opcode();
      logic [6:0] op;
      case ($urandom_range(0, 6))
         0: op = 7'h03;
         1: op = 7'h23;
         2: op = 7'h33;
         3: op = 7'h13;
         4: op = 7'h63;
         5: op = 7'h37;
         default: begin
            op = 7'($urandom_range(0, 127));
            if (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 ||
                op == 7'h63 || op == 7'h37) op = 7'h7F;
         end
      endcase
      return op;
   endfunction

   // Monitor: every cycle that has an expectation queued is compared at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (q_exp.size() > 0) begin
            mon_exp = q_exp.pop_front();
            mon_tag = q_tag.pop_front();
            total++;
            if (got !== mon_exp) begin
               bad++;
               $display("FAIL %s: got=%05h want=%05h", mon_tag, got, mon_exp);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      mem_bus.mem_ready = 1'b0;
      opcode = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
      cur_opc = 7'h03; cur_f3 = 3'd0; cur_f7 = 1'b0; cur_z = 1'b0;
      step(P_RST, 1'b1, 1'b1, 1'b0, "reset");
      step(P_RST, 1'b0, 1'b1, 1'b0, "reset");

      run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 0, -1);          // lw x5,8(x1)
      run_instr(7'h37, 3'd5, 1'b0, 1'b0, 0, 0, -1);          // lui x3,0x12345
      run_instr(7'h33, 3'd0, 1'b1, 1'b0, 0, 0, -1);          // sub x2,x3,x4
      run_instr(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, -1);          // same with funct7b5=0
      run_instr(7'h13, 3'd0, 1'b1, 1'b0, 1, 0, -1);          // addi never subtracts
      run_instr(7'h63, 3'd0, 1'b0, 1'b1, 0, 0, -1);          // beq taken
      run_instr(7'h63, 3'd0, 1'b0, 1'b0, 0, 0, -1);          // beq not taken
      run_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, WAIT_MAX + 1, -1); // store timeout
      run_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, WAIT_MAX, -1);     // ready on last cycle
      run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, -1);          // illegal opcode
      run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 5, 2);           // reset during MEMREAD
      run_instr(7'h33, 3'd7, 1'b0, 1'b0, WAIT_MAX + 1, 0, -1); // fetch timeout
      run_instr(7'h03, 3'd2, 1'b0, 1'b0, WAIT_MAX, WAIT_MAX + 2, -1);

      for (int k = 0; k < 60; k++) begin
         run_instr(rand_opcode(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rand_lat(), rand_lat(), -1);
      end

      @(negedge clk);
      #1;
      total++;
      if (q_exp.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d pending want=0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/unidad_de_control_multiciclo.md
Name: unidad_de_control_multiciclo

Overview:
Multicycle control FSM for the RV32I-subset microprocessor. It sequences fetch, decode, execute, memory and writeback over the shared ALU/memory datapath. It drives every mux select and write enable, including the 12/20-bit select of the sign extender (imn_src) and the instruction-field format feeding its 20-bit input. It also handles memory wait states with a timeout.

Parameters:
WAIT_MAX, 15, cycles a memory access may wait for mem_ready before abort (1..255)
CNT_W, 8, width of wait counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access request
mem_write  out  1  store strobe (valid with mem_req)
adr_src  out  1  0=PC, 1=ALUOut as memory address
ir_write  out  1  load instruction register and OldPC
pc_write  out  1  PC update enable
reg_write  out  1  register file write enable
alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=extended imm, 10=constant 4
alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
result_src  out  2  00=ALUOut, 01=data reg, 10=ALU result direct, 11=extended imm
imm_fmt  out  2  field mux to extender: 00 I {instr[31:20]}, 01 S {instr[31:25],instr[11:7]}, 10 U instr[31:12], 11 B {instr[31],instr[7],instr[30:25],instr[11:8]}
imn_src  out  1  extender mode: 1 only when imm_fmt=10 (U)
illegal_instr  out  1  one-cycle pulse on unsupported opcode
bus_error  out  1  one-cycle pulse on wait timeout

Behaviour:
- Moore outputs decoded from state. Exceptions: imm_fmt/imn_src are decoded combinationally from opcode in every state; pc_write in BEQ depends on zero; ir_write and pc_write in FETCH depend on mem_ready.
- Reset: state=FETCH, wait_cnt=0. While reset=1, all enables (mem_req, mem_write, ir_write, pc_write, reg_write) and pulses are 0, selects are 0, and alu_op=000.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=add, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 0110111 -> LUI; any other opcode -> ILLEGAL.
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00. alu_op from funct3: 000 gives add, or sub if funct7b5=1; 111 and; 110 or; 010 slt. Next is ALUWB.
- EXECI: as EXECR but alu_src_b=01, and funct7b5 is ignored (never sub).
- Unsupported funct3 in EXECR/EXECI: alu_op=add, no illegal pulse.
- ALUWB: result_src=00, reg_write=1, go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, go to FETCH.
- LUI: result_src=11, reg_write=1, go to FETCH.
- ILLEGAL: illegal_instr=1, no writes, go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEMREAD/MEMWRITE; increments each cycle that state waits without mem_ready.
  - When wait_cnt reaches WAIT_MAX with mem_ready=0: bus_error=1 that cycle, no ir/pc/reg/mem write enable asserted, go to FETCH (counter cleared).
  - mem_ready on the same cycle wait_cnt reaches WAIT_MAX counts as success, with no error.
- mem_ready outside a wait state is ignored.
- Reset mid-access aborts immediately: next cycle is FETCH with a fresh request.

Decomposition:
- Package pkg_control holds:
  - the state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, LUI, ILLEGAL;
  - opcode constants;
  - alu_op codes;
  - alu_src_a/alu_src_b/result_src/imm_fmt select codes.
- One sub-module: decodificador_alu (funct3, funct7b5, is_rtype -> alu_op), purely combinational.

Test Plan:
- lw x5,8(x1) = 0x0080A283, mem_ready immediate -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. imm_fmt=00, imn_src=0; reg_write=1 only in the MEMWB cycle.
- lui x3,0x12345 = 0x123451B7 -> imm_fmt=10, imn_src=1; LUI state gives result_src=11 and reg_write=1; total 3 cycles.
- sub x2,x3,x4 = 0x40418133 -> alu_op=001 in EXECR; the same instruction with funct7b5=0 gives 000.
- beq, run twice with zero=1 and zero=0 -> pc_write=1 in the BEQ state only when zero=1. imm_fmt=11 in both runs.
- Store with mem_ready held low 15 cycles -> bus_error pulses once at wait_cnt=15 with mem_write never committed, then FETCH. Repeat with ready on cycle 15 -> no error.
- Opcode 0x7F -> illegal_instr pulse for 1 cycle, then FETCH. Reset asserted during MEMREAD -> all enables 0 and state FETCH next cycle.
